// File: rtl/code_sequencer.sv
// code_sequencer: registered 4-bit code-word source (binary, BCD, Gray, excess-3)
// stepped by a free-running prescaler or manual pulses, presented over valid/ready.
module code_sequencer #(
  parameter int STEP_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       step,
  input  logic [1:0] mode,
  input  logic       dir,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       ready,
  output logic       valid,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       wrap,
  output logic       err
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [7:0] PS_LAST = 8'(STEP_DIV - 1);

  state_t     state, state_n;
  logic [7:0] ps_cnt, ps_cnt_n;
  logic [3:0] idx, idx_n, idx_fix;
  logic [3:0] code, code_n;
  logic [1:0] mode_q, mode_q_n;
  logic       wrap_n, err_n;
  logic       tick, trigger;

  function automatic logic [3:0] max_of(input logic [1:0] m);
    return m[0] ? 4'd9 : 4'd15;
  endfunction

  function automatic logic [3:0] encode(input logic [3:0] i, input logic [1:0] m);
    case (m)
      2'b10:   encode = i ^ (i >> 1);
      2'b11:   encode = i + 4'd3;
      default: encode = i;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ps_cnt <= '0;
      idx    <= '0;
      code   <= '0;
      mode_q <= '0;
      wrap   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      ps_cnt <= ps_cnt_n;
      idx    <= idx_n;
      code   <= code_n;
      mode_q <= mode_q_n;
      wrap   <= wrap_n;
      err    <= err_n;
    end
  end

  // The prescaler runs regardless of FSM state, so ticks landing in SEND are simply lost.
  always_comb begin
    tick     = en && (ps_cnt == PS_LAST);
    ps_cnt_n = '0;
    if (en && !tick)
      ps_cnt_n = ps_cnt + 8'd1;
    trigger  = en ? tick : step;
    idx_fix  = (idx > max_of(mode)) ? 4'd0 : idx;
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    code_n   = code;
    mode_q_n = mode_q;
    err_n    = err;
    wrap_n   = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          if (load_val <= max_of(mode)) begin
            idx_n = load_val;
            err_n = 1'b0;
          end else begin
            err_n = 1'b1;
          end
        end else if (trigger) begin
          mode_q_n = mode;
          idx_n    = idx_fix;
          code_n   = encode(idx_fix, mode);
          state_n  = SEND;
        end
      end
      SEND: begin
        // Advance uses the mode latched at presentation and dir as seen at acceptance.
        if (ready) begin
          if (!dir) begin
            if (idx == max_of(mode_q)) begin
              idx_n  = 4'd0;
              wrap_n = 1'b1;
            end else begin
              idx_n = idx + 4'd1;
            end
          end else begin
            if (idx == 4'd0) begin
              idx_n  = max_of(mode_q);
              wrap_n = 1'b1;
            end else begin
              idx_n = idx - 4'd1;
            end
          end
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign valid        = (state == SEND);
  assign {a, b, c, d} = code;

endmodule

// File: tb/tb_code_sequencer.sv
// tb_code_sequencer: scoreboard bench; a cycle-level reference model queues each
// expected word and a negedge monitor pops and compares as the DUT presents them.
module tb_code_sequencer;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst, en, step, dir, load, ready;
  logic [1:0] mode;
  logic [3:0] load_val;
  logic       valid, a, b, c, d, wrap, err;

  int checks   = 0;
  int failures = 0;

  code_sequencer #(.STEP_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .step(step), .mode(mode), .dir(dir),
    .load(load), .load_val(load_val), .ready(ready), .valid(valid),
    .a(a), .b(b), .c(c), .d(d), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int word;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   m_cnt, m_idx, m_word, m_mode;
  bit   m_busy, m_err, m_wrap;
  bit   started = 1'b0;
  logic prev_valid = 1'b0;

  function automatic int max_index(int m);
    return (m % 2 == 1) ? 9 : 15;
  endfunction

  function automatic int code_of(int i, int m);
    int r;
    case (m)
      2:       r = i ^ (i / 2);
      3:       r = i + 3;
      default: r = i;
    endcase
    return r;
  endfunction

  // Reference model: index walks a ring of size MAX+1; one word in flight at most.
  always @(posedge clk) begin : model
    bit trig;
    int n, old;
    cyc++;
    if (rst) begin
      m_cnt = 0; m_busy = 0; m_idx = 0; m_err = 0;
      m_wrap = 0; m_word = 0; m_mode = 0;
    end else begin
      trig   = en ? (m_cnt == DIV - 1) : step;
      m_cnt  = en ? (m_cnt + 1) % DIV : 0;
      m_wrap = 0;
      if (!m_busy) begin
        if (load) begin
          if (int'(load_val) <= max_index(int'(mode))) begin
            m_idx = int'(load_val);
            m_err = 0;
          end else begin
            m_err = 1;
          end
        end else if (trig) begin
          m_mode = int'(mode);
          if (m_idx > max_index(m_mode)) m_idx = 0;
          m_word = code_of(m_idx, m_mode);
          m_busy = 1;
          exp_q.push_back('{cyc, m_word});
        end
      end else if (ready) begin
        n      = max_index(m_mode) + 1;
        old    = m_idx;
        m_idx  = (m_idx + (dir ? n - 1 : 1)) % n;
        m_wrap = dir ? (old == 0) : (m_idx == 0);
        m_busy = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (started) begin
      checkOutput("valid", 32'(valid), 32'(m_busy));
      checkOutput("abcd", 32'({a, b, c, d}), 32'(m_word));
      checkOutput("wrap", 32'(wrap), 32'(m_wrap));
      checkOutput("err", 32'(err), 32'(m_err));
      if (valid === 1'b1 && prev_valid !== 1'b1) begin
        checkOutput("expected_word_queued", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkOutput("word_cycle", 32'(cyc), 32'(e.cyc));
          checkOutput("word_code", 32'({a, b, c, d}), 32'(e.word));
        end
      end
      prev_valid = valid;
    end
  end

  task automatic applyStimulus(input bit e, input bit [1:0] md, input bit dr, input bit rdy, input int n);
    en = e; mode = md; dir = dr; ready = rdy; step = 1'b0; load = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doLoad(input bit [3:0] v);
    load = 1'b1; load_val = v;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic doStep();
    step = 1'b1;
    @(posedge clk);
    #1;
    step = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; step = 1'b0; dir = 1'b0; load = 1'b0;
    ready = 1'b0; mode = 2'b00; load_val = 4'd0;
    @(posedge clk);
    #1;
    started = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Free-run binary up through a full wrap
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b1, 17 * DIV + 4);

    // BCD then Gray, each restarted from index 0
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b1, 3);
    doLoad(4'd0);
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b1, 12 * DIV);
    applyStimulus(1'b0, 2'b10, 1'b0, 1'b1, 3);
    doLoad(4'd0);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b1, 18 * DIV);

    // Excess-3 counting down from 0 wraps to 9
    applyStimulus(1'b0, 2'b11, 1'b1, 1'b1, 3);
    doLoad(4'd0);
    applyStimulus(1'b1, 2'b11, 1'b1, 1'b1, 3 * DIV);

    // Back-pressure: ticks during a stalled word are dropped
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 20);
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b1, 3 * DIV);

    // Out-of-range load, valid load, load during SEND ignored
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b1, 3);
    doLoad(4'd12);
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b1, 2);
    doLoad(4'd5);
    doStep();
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b0, 2);
    doStep();
    doLoad(4'd2);
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b1, 2);
    doStep();
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b1, 3);

    // Manual stepping, then reset in the middle of a presented word
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 2);
    repeat (5) begin
      doStep();
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 2 + $urandom_range(0, 3));
    end
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1);
    doStep();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 2);
    doReset();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 2);
    doStep();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 3);

    // Randomized mix of everything
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 11))
        0, 1:    doLoad(4'($urandom_range(0, 15)));
        2, 3:    doStep();
        4:       doReset();
        default: applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                               1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                               int'($urandom_range(1, 8)));
      endcase
    end
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 4);

    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/code_sequencer.md
Name: code_sequencer

Overview:
- Registered 4-bit code-word source that sits directly upstream of code_converter and drives its a, b, c, d inputs.
- Generates binary, BCD, Gray or excess-3 sequences, up or down.
- Steps either free-running (prescaled) or by single-step pulses.
- Presents each word with a valid/ready handshake so the downstream stage (or a bench) consumes exactly one word per transfer.

Parameters:
STEP_DIV, 4, clock cycles between free-run ticks (legal range 2..255).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
en  input  1  1 = free-run stepping via prescaler; 0 = manual stepping
step  input  1  single-cycle manual step request, honoured only when en=0
mode  input  2  00 binary, 01 BCD, 10 Gray, 11 excess-3
dir  input  1  0 = index increments, 1 = index decrements
load  input  1  load index from load_val
load_val  input  4  index value to load
ready  input  1  downstream accepts the current word
valid  output  1  a/b/c/d hold a valid word
a  output  1  code bit 3 (MSB)
b  output  1  code bit 2
c  output  1  code bit 1
d  output  1  code bit 0 (LSB)
wrap  output  1  one-cycle pulse when an accepted advance wraps the index
err  output  1  sticky flag: last load was out of range for the mode

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - idx=0, state=IDLE, mode_q=00, prescaler=0.
  - valid=0, {a,b,c,d}=0000, wrap=0, err=0.
  - Reset applied in any state, including SEND, aborts the current word; valid is 0 on the next cycle.
- Index range:
  - MAX=15 for modes 00 and 10.
  - MAX=9 for modes 01 and 11.
- Code mapping from idx, computed from mode_q:
  - binary = idx.
  - BCD = idx.
  - Gray = idx ^ (idx>>1).
  - excess-3 = idx+3, 4-bit, range 3..12.
- Prescaler:
  - While en=1, counts 0..STEP_DIV-1 continuously, independent of FSM state.
  - tick=1 in the cycle the count equals STEP_DIV-1.
  - While en=0, the prescaler is held at 0.
- Trigger:
  - en=1: trigger = tick.
  - en=0: trigger = step.
  - step is ignored while en=1.
- FSM:
  - IDLE (valid=0). On trigger:
    - Sample mode into mode_q.
    - If idx > MAX(mode), force idx=0.
    - Register the code onto a/b/c/d.
    - Next state SEND, so valid=1 one cycle after the trigger.
  - SEND (valid=1):
    - a/b/c/d and mode_q are held stable until valid&ready.
    - On valid&ready, advance idx: up = idx==MAX ? 0 : idx+1; down = idx==0 ? MAX : idx-1.
    - wrap=1 in the next cycle only if that advance wrapped.
    - Next state IDLE; valid=0 next cycle.
  - Triggers arriving while in SEND are dropped; there is no queue.
- Load:
  - Honoured only in IDLE; ignored in SEND.
  - If load_val <= MAX(mode): idx=load_val, err=0.
  - Otherwise idx is unchanged and err=1.
  - A load and a trigger in the same IDLE cycle: load wins and the trigger is dropped.
- a/b/c/d keep the last presented word while in IDLE.
- mode or dir changes while in SEND do not alter the presented word. dir is sampled at acceptance.
- With en=1, ready=1 and STEP_DIV=S, a new word is presented every S cycles.

Test Plan:
1. Reset, then en=1, mode=00, dir=0, ready=1, STEP_DIV=4 -> valid high 1 cycle every 4 cycles with codes 0,1,2,…,15,0. wrap pulses once after the 15 is accepted. err=0 throughout.
2. mode=01, up -> codes 0..9 then 0, with wrap after 9. mode=10 -> codes 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8,0.
3. mode=11, dir=1, load load_val=0 in IDLE -> first code 3 (0011), second code 12 (1100, idx 9), wrap pulse at that transition.
4. ready=0 for 20 cycles while en=1 -> valid stays 1 and abcd stays constant, intermediate ticks dropped. Then ready=1 -> one acceptance, next word is idx+1 (no skipped indices).
5. mode=01, load load_val=12 -> err=1, idx unchanged. Then load load_val=5 -> err=0, next presented code 0101. Load asserted during SEND -> ignored.
6. en=0, step pulses with ready=1 -> exactly one word per pulse, each valid 1 cycle after its step. rst=1 during SEND -> valid=0, abcd=0000, next word after reset is 0.
